user_maxil_device: RTL and testbench

AXI4-Lite read-channel initiator (master). It is the counterpart of the team's AXI-Lite read slave devices. It accepts single-word read commands from local user logic over a valid/ready command port, drives the AR and R channels, and returns data and response on a valid/ready result port. A data-phase timeout flags slaves that never answer, so user logic is not hung.

---
 rtl/axil_pkg.sv | 29 ++
 rtl/axil_timeout_cnt.sv | 45 ++++
 rtl/user_maxil_device.sv | 166 ++++++++++++++++
 tb/tb_user_maxil_device.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the read initiator.
// Holds the read FSM state encoding, the RRESP codes and the AXI-Lite data width.
package axil_pkg;

   // The AXI-Lite data bus is one 32-bit word.
   localparam int AXIL_DATA_W = 32;

   // Read FSM state encoding.
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      ADDR  = ST_ADDR,
      DATA  = ST_DATA,
      RESP  = ST_RESP,
      FLUSH = ST_FLUSH
   } state_t;

   // RRESP codes.
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Data-phase timeout counter.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : zero the count (takes priority over enable)
//   enable     : advance the count by one this cycle
//   expire     : high in the cycle whose increment brings the count to
//                TIMEOUT_CYCLES; tied low when TIMEOUT_CYCLES = 0
module axil_timeout_cnt
   import axil_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (TIMEOUT_CYCLES != 0)) begin
         count <= count + CW'(1);
      end
   end

   // Expire is flagged by the increment that would reach the limit, so the
   // caller sees exactly TIMEOUT_CYCLES enabled cycles before it fires.
   generate
      if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
         assign expire = 1'b0;
      end else begin : g_timeout
         assign expire = enable && !clear && (count == LAST);
      end
   endgenerate

endmodule

// File: rtl/user_maxil_device.sv
// AXI4-Lite read initiator. Takes single-word read commands on a valid/ready
// command port, runs the AR and R channels, and returns data/response on a
// valid/ready result port. A data-phase timeout answers for silent slaves.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a valid is never withdrawn and its payload never changes until
// that transfer.
// Ports:
//   user_maxil_clk, user_maxil_rst_n    : clock, synchronous active-low reset
//   cmd_valid/cmd_ready/cmd_addr        : read command from user logic
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_resp/rsp_timeout                : read result to user logic
//   user_port_ar*                       : AXI-Lite read address channel
//   user_port_r*                        : AXI-Lite read data channel
//   dbg_state                           : current FSM state (axil_pkg encoding)
module user_maxil_device
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  user_maxil_clk,
   input  logic                  user_maxil_rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_resp,
   output logic                  rsp_timeout,
   output logic                  user_port_arvalid,
   input  logic                  user_port_arready,
   output logic [ADDR_WIDTH-1:0] user_port_araddr,
   output logic [2:0]            user_port_arprot,
   input  logic                  user_port_rvalid,
   output logic                  user_port_rready,
   input  logic [DATA_WIDTH-1:0] user_port_rdata,
   input  logic [1:0]            user_port_rresp,
   output logic [2:0]            dbg_state
);

   state_t                state, state_d;
   logic                  cmd_ready_d;
   logic                  arvalid_d, rready_d;
   logic [ADDR_WIDTH-1:0] araddr_d;
   logic                  rsp_valid_d, rsp_timeout_d;
   logic [DATA_WIDTH-1:0] rsp_data_d;
   logic [1:0]            rsp_resp_d;
   logic                  cnt_clear, cnt_enable, cnt_expire;

   axil_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (user_maxil_clk),
      .rst_n  (user_maxil_rst_n),
      .clear  (cnt_clear),
      .enable (cnt_enable),
      .expire (cnt_expire)
   );

   assign user_port_arprot = 3'b000;
   assign dbg_state        = state;

   always_ff @(posedge user_maxil_clk) begin
      if (!user_maxil_rst_n) begin
         state             <= IDLE;
         cmd_ready         <= 1'b0;
         user_port_arvalid <= 1'b0;
         user_port_araddr  <= '0;
         user_port_rready  <= 1'b0;
         rsp_valid         <= 1'b0;
         rsp_data          <= '0;
         rsp_resp          <= OKAY;
         rsp_timeout       <= 1'b0;
      end else begin
         state             <= state_d;
         cmd_ready         <= cmd_ready_d;
         user_port_arvalid <= arvalid_d;
         user_port_araddr  <= araddr_d;
         user_port_rready  <= rready_d;
         rsp_valid         <= rsp_valid_d;
         rsp_data          <= rsp_data_d;
         rsp_resp          <= rsp_resp_d;
         rsp_timeout       <= rsp_timeout_d;
      end
   end

   always_comb begin
      state_d       = state;
      arvalid_d     = user_port_arvalid;
      araddr_d      = user_port_araddr;
      rready_d      = user_port_rready;
      rsp_valid_d   = rsp_valid;
      rsp_data_d    = rsp_data;
      rsp_resp_d    = rsp_resp;
      rsp_timeout_d = rsp_timeout;
      cnt_clear     = 1'b0;
      cnt_enable    = 1'b0;

      case (state)
         IDLE: begin
            // cmd_ready is still low for the first cycle out of reset.
            if (cmd_valid && cmd_ready) begin
               araddr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
               arvalid_d = 1'b1;
               state_d   = ADDR;
            end
         end
         ADDR: begin
            if (user_port_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_clear = 1'b1;
               state_d   = DATA;
            end
         end
         DATA: begin
            // The counter only runs on cycles without rvalid, so a response
            // arriving in the expiring cycle wins over the timeout.
            if (user_port_rvalid) begin
               rsp_data_d    = user_port_rdata;
               rsp_resp_d    = user_port_rresp;
               rsp_timeout_d = 1'b0;
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = RESP;
            end else begin
               cnt_enable = 1'b1;
               if (cnt_expire) begin
                  rsp_data_d    = '0;
                  rsp_resp_d    = SLVERR;
                  rsp_timeout_d = 1'b1;
                  rsp_valid_d   = 1'b1;
                  state_d       = FLUSH;
               end
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         FLUSH: begin
            // Result delivery and absorbing the late R beat finish
            // independently; each register doubles as its own pending flag.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
            if (user_port_rvalid) begin
               rready_d = 1'b0;
            end
            if (!rsp_valid_d && !rready_d) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
   end

endmodule

// File: tb/tb_user_maxil_device.sv
module tb_user_maxil_device;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_resp;
   logic          rsp_timeout;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [AW-1:0] araddr;
   logic [2:0]    arprot;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = '0;
   logic [2:0]    dbg_state;

   user_maxil_device #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .user_maxil_clk    (clk),
      .user_maxil_rst_n  (rst_n),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_addr          (cmd_addr),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_data          (rsp_data),
      .rsp_resp          (rsp_resp),
      .rsp_timeout       (rsp_timeout),
      .user_port_arvalid (arvalid),
      .user_port_arready (arready),
      .user_port_araddr  (araddr),
      .user_port_arprot  (arprot),
      .user_port_rvalid  (rvalid),
      .user_port_rready  (rready),
      .user_port_rdata   (rdata),
      .user_port_rresp   (rresp),
      .dbg_state         (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [34:0] exp_q[$];   // {timeout, resp, data} per expected result

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: a read whose R beat is offered on data-phase cycle
   // r_delay (1 = first cycle rready is high) is answered by the slave when
   // r_delay <= TO, otherwise it times out with SLVERR and zero data.
   function automatic logic [34:0] model_rsp(input int r_delay, input logic [31:0] d,
                                             input logic [1:0] r);
      if (r_delay <= TO) return {1'b0, r, d};
      return {1'b1, 2'b10, 32'h0};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input logic [31:0] addr, input int ar_wait, input int r_delay,
                          input int rsp_wait, input int late_wait,
                          input logic [31:0] d, input logic [1:0] r);
      logic [31:0] exp_addr;
      logic [34:0] got;
      bit          timed_out;
      int          n_data;
      int          last;
      exp_addr  = {addr[31:2], 2'b00};
      timed_out = (r_delay > TO);
      exp_q.push_back(model_rsp(r_delay, d, r));

      check("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      step();
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      check("cmd_ready_drop", cmd_ready, 0);

      // Address phase; rvalid noise here must be ignored.
      for (int i = 0; i <= ar_wait; i++) begin
         check("arvalid_hold", arvalid, 1);
         check("araddr", araddr, exp_addr);
         check("arprot", arprot, 0);
         check("rready_in_addr", rready, 0);
         arready = (i == ar_wait);
         rvalid  = 1'($urandom_range(0, 1));
         rdata   = $urandom;
         step();
      end
      arready = 1'b0;
      rvalid  = 1'b0;
      check("arvalid_done", arvalid, 0);

      // Data phase.
      n_data = timed_out ? TO : r_delay;
      for (int j = 1; j <= n_data; j++) begin
         check("rready_data", rready, 1);
         check("rsp_valid_early", rsp_valid, 0);
         if (!timed_out && j == r_delay) begin
            rvalid = 1'b1;
            rdata  = d;
            rresp  = r;
         end
         step();
      end
      rvalid = 1'b0;
      rdata  = $urandom;
      rresp  = 2'($urandom_range(0, 3));

      check("rsp_valid_rise", rsp_valid, 1);
      got = {rsp_timeout, rsp_resp, rsp_data};
      check("rsp_payload", got, exp_q.pop_front());
      check("rready_after_data", rready, timed_out ? 1 : 0);
      check("cmd_ready_in_rsp", cmd_ready, 0);

      // Result delivery (and late R absorption after a timeout).
      last = rsp_wait;
      if (timed_out && late_wait > last) last = late_wait;
      for (int c = 0; c <= last; c++) begin
         rsp_ready = (c == rsp_wait);
         rvalid    = timed_out && (c == late_wait);
         rdata     = $urandom;
         cmd_valid = (c < last) ? 1'($urandom_range(0, 1)) : 1'b0;
         cmd_addr  = $urandom;
         step();
         check("rsp_valid_hold", rsp_valid, (c < rsp_wait) ? 1 : 0);
         if (c < rsp_wait) check("rsp_stable", {rsp_timeout, rsp_resp, rsp_data}, got);
         check("rready_flush", rready, (timed_out && c < late_wait) ? 1 : 0);
         check("cmd_ready_return", cmd_ready, (c == last) ? 1 : 0);
         check("no_new_ar", arvalid, 0);
      end
      rsp_ready = 1'b0;
      rvalid    = 1'b0;
      cmd_valid = 1'b0;
   endtask

   task automatic check_reset_outs(input string tag, input logic exp_cmd_ready);
      check({tag, "_ctl"}, {cmd_ready, arvalid, rready, rsp_valid, rsp_timeout, rsp_resp},
            {exp_cmd_ready, 6'b0});
      check({tag, "_araddr"}, araddr, 0);
      check({tag, "_rsp_data"}, rsp_data, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Power-on reset.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_reset_outs("por", 1'b0);
      end
      rst_n = 1'b1;
      step();
      check_reset_outs("por_release", 1'b1);
      check("state_idle", dbg_state, 0);

      // Directed cases.
      run_txn(32'h0000_1007, 0, 1, 0, 0, 32'hDEAD_BEEF, 2'b00);
      check("araddr_kept", araddr, 32'h0000_1004);
      run_txn($urandom, 10, 2, 0, 0, $urandom, 2'b11);
      run_txn($urandom, 0, 1, 5, 0, $urandom, 2'b01);
      run_txn($urandom, 0, TO + 1, 0, 20, $urandom, 2'b00);   // timeout, late R
      run_txn($urandom, 1, TO, 2, 0, $urandom, 2'b00);        // rvalid on the limit
      run_txn($urandom, 0, TO + 1, 6, 2, $urandom, 2'b00);    // R absorbed before rsp
      run_txn($urandom, 2, TO + 1, 3, 3, $urandom, 2'b00);    // both in same cycle

      // Reset held 3 cycles in the middle of the data phase.
      cmd_valid = 1'b1;
      cmd_addr  = $urandom;
      step();
      cmd_valid = 1'b0;
      arready   = 1'b1;
      step();
      arready   = 1'b0;
      step();
      check("mid_data_rready", rready, 1);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_reset_outs("mid_rst", 1'b0);
      end
      rst_n = 1'b1;
      step();
      check_reset_outs("mid_release", 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_rready_after_rst", {rready, arvalid, rsp_valid}, 0);
      end

      // Randomised transactions.
      for (int t = 0; t < 40; t++) begin
         run_txn($urandom, $urandom_range(0, 4), $urandom_range(1, TO + 3),
                 $urandom_range(0, 4), $urandom_range(0, 5), $urandom,
                 2'($urandom_range(0, 3)));
      end

      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

endmodule
